// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and constants for the FIFO write arbiter slice.
//   - arb_state_t : arbiter FSM states (IDLE, BURST, GAP)
//   - FIFO_DEPTH  : depth of the shared synchronous FIFO
//   - FIFO_DW     : data width of the shared FIFO
//   - BEAT_W      : width of the per-grant beat counter
//   - wrap_add    : (base + off) mod n for base < n, off <= n
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW    = 8;
  localparam int BEAT_W     = 4;

  // Modulo add without a divider; the operands never exceed 2*n-1, so a
  // single conditional subtract is enough and non-power-of-2 n works.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin priority select. Scans the request vector
//   starting one position after the last grant and wrapping modulo N_REQ.
//   Ports:
//     req  in  N_REQ  request vector
//     last in  IW     index of the most recent grant
//     idx  out IW     selected index (equals last when nothing requests)
//     any  out 1      at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // cand[k] is the producer examined at priority rank k (rank 0 = highest).
  logic [IW-1:0]    cand [N_REQ];
  logic [N_REQ-1:0] hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rank
    assign cand[gi] = IW'(wrap_add(int'(last), gi + 1, N_REQ));
    assign hit[gi]  = req[cand[gi]];
  end

  // Scan from the lowest rank last so the highest-priority hit wins.
  always_comb begin
    idx = last;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter sharing one synchronous FIFO among N_REQ
//   producers. One producer is granted at a time for up to MAX_BURST beats;
//   after a burst, if the consumer is waiting on a non-empty FIFO, one idle
//   write cycle (GAP) is inserted so the FIFO read can win.
//   Ports:
//     clk          in   1          clock
//     rst          in   1          synchronous active-high reset
//     req_valid    in   N_REQ      per-producer data valid
//     req_data     in   N_REQ*DW   packed producer data, slice i = [i*DW +: DW]
//     req_ready    out  N_REQ      per-producer ready (combinational)
//     fifo_wr      out  1          FIFO write strobe (combinational)
//     fifo_din     out  DW         FIFO write data (granted slice)
//     fifo_full    in   1          FIFO full flag
//     fifo_empty   in   1          FIFO empty flag
//     fifo_rd_req  in   1          consumer intends to read this cycle
//     grant_valid  out  1          registered, high while in BURST
//     grant_id     out  IW         registered, current or last granted index
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  input  logic                fifo_rd_req,
  output logic                grant_valid,
  output logic [IW-1:0]       grant_id
);

  arb_state_t        state_reg, state_next;
  logic [IW-1:0]     grant_id_reg, grant_id_next;
  logic [IW-1:0]     last_grant_reg, last_grant_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic              grant_valid_reg, grant_valid_next;

  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              in_burst;
  logic              transfer;
  logic              last_beat;
  logic              burst_exit;
  logic [DW-1:0]     slice [N_REQ];

  // Unpack the producer data bus once so the write mux is a plain index.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice[gi] = req_data[gi*DW +: DW];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_grant_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Gating with rst keeps the reset cycle free of handshakes even when the
  // reset lands in the middle of a burst.
  assign in_burst   = (state_reg == BURST) && !rst;
  assign transfer   = in_burst && req_valid[grant_id_reg] && !fifo_full;
  assign last_beat  = transfer && ((beat_cnt_reg + BEAT_W'(1)) == BEAT_W'(MAX_BURST));
  // A final beat coinciding with valid dropping is still a full-burst exit;
  // both paths lead to the same release, so they share one condition.
  assign burst_exit = last_beat || !req_valid[grant_id_reg];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= '0;
      beat_cnt_reg    <= '0;
      last_grant_reg  <= IW'(N_REQ - 1);
    end else begin
      state_reg       <= state_next;
      grant_valid_reg <= grant_valid_next;
      grant_id_reg    <= grant_id_next;
      beat_cnt_reg    <= beat_cnt_next;
      last_grant_reg  <= last_grant_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next       = state_reg;
    grant_valid_next = grant_valid_reg;
    grant_id_next    = grant_id_reg;
    beat_cnt_next    = beat_cnt_reg;
    last_grant_next  = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next       = BURST;
          grant_valid_next = 1'b1;
          grant_id_next    = pick_idx;
          beat_cnt_next    = '0;
        end
      end
      BURST: begin
        // A full FIFO stalls the burst in place; the grant is kept.
        if (transfer) begin
          beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
        end
        if (burst_exit) begin
          grant_valid_next = 1'b0;
          last_grant_next  = grant_id_reg;
          state_next       = (fifo_rd_req && !fifo_empty) ? GAP : IDLE;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next       = IDLE;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    fifo_wr   = transfer;
    fifo_din  = slice[grant_id_reg];
    if (in_burst && !fifo_full) begin
      req_ready[grant_id_reg] = 1'b1;
    end
  end

  assign grant_valid = grant_valid_reg;
  assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter. Producers are byte queues, the FIFO
//   is a queue of FIFO_DEPTH entries with write-over-read priority, and a
//   transaction-level arbiter model predicts every output each cycle.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int IW        = $clog2(N_REQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_wr;
  logic [DW-1:0]       fifo_din;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_rd_req;
  logic                grant_valid;
  logic [IW-1:0]       grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N_REQ),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wr     (fifo_wr),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_rd_req (fifo_rd_req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Environment
  logic [7:0] src_q [N_REQ][$];
  logic [7:0] fifo_q[$];
  bit         rd_en = 1'b0;

  // Arbiter model: owner < 0 means nobody holds the grant
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N_REQ - 1;
  int m_gid   = 0;
  bit m_gap   = 1'b0;
  bit m_known = 1'b0;

  // Log of predicted writes
  int         log_cyc[$];
  int         log_src[$];
  logic [7:0] log_dat[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_idle();
    bit srcs_empty = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) srcs_empty = 1'b0;
    return srcs_empty && (m_owner < 0) && !m_gap;
  endfunction

  // One clock cycle: drive, compare, advance environment and model.
  task automatic step(input bit r);
    bit             full, empty, exp_wr, bursting, found;
    bit [N_REQ-1:0] exp_rdy;
    int             cand;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]          = (src_q[i].size() != 0);
      req_data[i*DW +: DW]  = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
    full        = (fifo_q.size() == FIFO_DEPTH);
    empty       = (fifo_q.size() == 0);
    fifo_full   = full;
    fifo_empty  = empty;
    fifo_rd_req = rd_en;
    #1;
    bursting = !r && (m_owner >= 0);
    exp_rdy  = '0;
    exp_wr   = 1'b0;
    if (bursting) begin
      exp_rdy[m_owner] = !full;
      exp_wr           = req_valid[m_owner] && !full;
    end
    check("req_ready", int'(req_ready), int'(exp_rdy));
    check("fifo_wr", int'(fifo_wr), int'(exp_wr));
    if (exp_wr) check("fifo_din", int'(fifo_din), int'(src_q[m_owner][0]));
    if (m_known) begin
      check("grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
      check("grant_id", int'(grant_id), m_gid);
    end
    // FIFO: a write blocks the read in the same cycle
    if (exp_wr) begin
      log_cyc.push_back(cyc);
      log_src.push_back(m_owner);
      log_dat.push_back(src_q[m_owner][0]);
      fifo_q.push_back(src_q[m_owner].pop_front());
    end else if (rd_en && !empty) begin
      void'(fifo_q.pop_front());
    end
    // Arbiter rules
    if (r) begin
      m_owner = -1; m_beats = 0; m_last = N_REQ - 1; m_gid = 0;
      m_gap = 1'b0; m_known = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
        cand = (m_last + k) % N_REQ;
        if (!found && req_valid[cand]) begin
          found = 1'b1; m_owner = cand; m_gid = cand; m_beats = 0;
        end
      end
    end else begin
      if (exp_wr) m_beats++;
      if ((exp_wr && m_beats == MAX_BURST) || !req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = rd_en && !empty;
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while (!model_idle() && n < max_cyc) begin
      step(1'b0);
      n++;
    end
    check("settle_timeout", int'(model_idle()), 1);
  endtask

  task automatic drain();
    int n = 0;
    rd_en = 1'b1;
    while (!(model_idle() && fifo_q.size() == 0) && n < 60) begin
      step(1'b0);
      n++;
    end
    rd_en = 1'b0;
    check("drain_timeout", fifo_q.size(), 0);
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_src.delete(); log_dat.delete();
  endtask

  task automatic wait_log(input int count, input int max_cyc);
    int n = 0;
    while (log_dat.size() < count && n < max_cyc) begin
      step(1'b0);
      n++;
    end
    check("log_timeout", log_dat.size(), count);
  endtask

  initial begin
    int start;
    rst = 1'b1; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rd_req = 1'b0;

    // Reset state
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("rst_grant_valid", int'(grant_valid), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_fifo_wr", int'(fifo_wr), 0);

    // 1: single producer, 6 bytes, bursts of 4 then 2
    clear_log();
    for (int i = 0; i < 6; i++) src_q[1].push_back(8'(8'h10 + i));
    start = cyc;
    run_until_idle(40);
    check("t1_count", log_dat.size(), 6);
    if (log_dat.size() == 6) begin
      check("t1_latency", log_cyc[0], start + 1);
      for (int i = 0; i < 6; i++) begin
        check("t1_data", int'(log_dat[i]), 8'h10 + i);
        check("t1_src", log_src[i], 1);
      end
      check("t1_back2back", log_cyc[3] - log_cyc[0], 3);
      check("t1_idle_gap", log_cyc[4] - log_cyc[3], 2);
    end
    drain();

    // 2: producers 0 and 2 alternate, 4 beats each
    step(1'b1);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      src_q[0].push_back(8'(8'h20 + i));
      src_q[2].push_back(8'(8'h40 + i));
    end
    run_until_idle(60);
    check("t2_count", log_dat.size(), 16);
    if (log_dat.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("t2_src", log_src[i], ((i / 4) % 2 == 0) ? 0 : 2);
        check("t2_data", int'(log_dat[i]),
              (((i / 4) % 2 == 0) ? 8'h20 : 8'h40) + (i / 8) * 4 + (i % 4));
      end
    end
    drain();

    // 3: FIFO one short of full, producer 3 stalls on full
    clear_log();
    for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_q.push_back(8'hEE);
    src_q[3].push_back(8'hA0);
    src_q[3].push_back(8'hA1);
    wait_log(1, 10);
    step(1'b0);
    step(1'b0);
    rd_en = 1'b1;
    step(1'b0);
    rd_en = 1'b0;
    wait_log(2, 10);
    if (log_dat.size() == 2) begin
      check("t3_d0", int'(log_dat[0]), 8'hA0);
      check("t3_d1", int'(log_dat[1]), 8'hA1);
      check("t3_stall", log_cyc[1] - log_cyc[0], 4);
    end
    drain();

    // 4: consumer waiting at burst exit forces one GAP cycle
    clear_log();
    for (int i = 0; i < 6; i++) src_q[0].push_back(8'(8'h50 + i));
    rd_en = 1'b1;
    run_until_idle(40);
    rd_en = 1'b0;
    check("t4_count", log_dat.size(), 6);
    if (log_dat.size() == 6) begin
      check("t4_burst", log_cyc[3] - log_cyc[0], 3);
      check("t4_gap", log_cyc[4] - log_cyc[3], 3);
    end
    drain();

    // 5: producer 1 drops valid after 2 beats, producer 2 pending
    clear_log();
    src_q[1].push_back(8'h61); src_q[1].push_back(8'h62);
    src_q[2].push_back(8'h71); src_q[2].push_back(8'h72);
    run_until_idle(40);
    check("t5_count", log_dat.size(), 4);
    if (log_dat.size() == 4) begin
      check("t5_src0", log_src[0], 1);
      check("t5_src1", log_src[1], 1);
      check("t5_src2", log_src[2], 2);
      check("t5_d2", int'(log_dat[2]), 8'h71);
      check("t5_regrant", log_cyc[2] - log_cyc[1], 3);
    end
    check("t5_last", m_last, 2);
    drain();

    // 6: reset after beat 2, producer 0 first afterwards
    clear_log();
    for (int i = 0; i < 4; i++) src_q[2].push_back(8'(8'h90 + i));
    wait_log(2, 10);
    step(1'b1);
    check("t6_no_wr_in_rst", log_dat.size(), 2);
    src_q[0].push_back(8'h80);
    src_q[0].push_back(8'h81);
    step(1'b0);
    check("t6_gv_after_rst", int'(grant_valid), 0);
    check("t6_wr_after_rst", int'(fifo_wr), 0);
    run_until_idle(40);
    check("t6_count", log_dat.size(), 6);
    if (log_dat.size() == 6) begin
      check("t6_first_src", log_src[2], 0);
      check("t6_first_dat", int'(log_dat[2]), 8'h80);
      check("t6_resume_dat", int'(log_dat[4]), 8'h92);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous 16-deep x 8-bit FIFO among N_REQ producers. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write port (wr/din), honouring the FIFO's full flag. The FIFO gives write priority over read in the same cycle, so the arbiter inserts a one-cycle write gap after a burst when the consumer is waiting, which prevents reader starvation.

Parameters:
N_REQ, 4, number of producers (2..8)
DW, 8, data width; equals FIFO data width
MAX_BURST, 4, maximum beats per grant (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  N_REQ  per-producer data valid
req_data  in  N_REQ*DW  packed producer data; slice i = bits [i*DW +: DW]
req_ready  out  N_REQ  per-producer ready (combinational)
fifo_wr  out  1  FIFO write strobe (combinational)
fifo_din  out  DW  FIFO write data (combinational mux of granted slice)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_req  in  1  consumer intends to read this cycle
grant_valid  out  1  registered; 1 while in BURST
grant_id  out  clog2(N_REQ)  registered; index of the current or last granted producer

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, grant_valid=0, grant_id=0, beat_cnt=0, last_grant=N_REQ-1 (so producer 0 wins first).
  - req_ready=0 and fifo_wr=0 during and after reset until a grant exists.
  - Reset mid-burst aborts the burst; no beat is written in the reset cycle.
- Transfer definition: a beat transfers in a cycle iff state==BURST && req_valid[g] && !fifo_full, where g=grant_id.
  - req_ready[g] = (state==BURST) && !fifo_full. All other req_ready bits are 0.
  - fifo_wr = transfer. fifo_din = req_data slice g; it is a don't-care when fifo_wr=0 (drive the slice anyway).
- States:
  - IDLE:
    - No writes.
    - If any req_valid, select the first set bit scanning last_grant+1, +2, ... modulo N_REQ.
    - Register grant_id, set grant_valid=1, beat_cnt=0, go to BURST.
    - Latency: req_valid rising in IDLE gives the first possible transfer in the next cycle.
  - BURST:
    - On a transfer, beat_cnt increments.
    - Exit when the transfer makes beat_cnt==MAX_BURST, or when req_valid[g]==0 in a cycle (no transfer that cycle).
    - On exit: last_grant=g, grant_valid=0. Next state is GAP if fifo_rd_req && !fifo_empty is sampled in the exit cycle, otherwise IDLE.
    - While fifo_full: no transfer, beat_cnt holds, grant is held. The grant is not released because of full.
  - GAP: exactly one cycle, no writes (lets the FIFO read win), then IDLE.
- Widths: beat_cnt is 4 bits; the rotation index wraps modulo N_REQ (non-power-of-2 N_REQ must be handled).
- Throughput: a burst of MAX_BURST beats occupies 1 (IDLE) + MAX_BURST cycles, plus 1 GAP cycle when applicable.
- Simultaneous events:
  - The last beat and req_valid deassert in the same cycle count as a MAX_BURST exit.
  - A full flag deasserting makes the transfer legal in that same cycle.
- Data is never dropped: fifo_wr is never asserted while fifo_full=1.

Decomposition:
- Package fifo_arb_pkg: state enum {IDLE, BURST, GAP}, and the FIFO depth constant 16 for benches.
- Sub-module rr_pick: combinational round-robin priority select (inputs req vector and last_grant; outputs index and any).

Test Plan:
- Single producer 1 with valid held and 6 bytes 0x10..0x15, FIFO empty -> grant_id=1; 0x10..0x13 written on 4 consecutive cycles; one IDLE cycle; then 0x14, 0x15 written.
- Producers 0 and 2 both valid continuously -> grant order 0, 2, 0, 2, 4 beats each; no beat duplicated or lost.
- FIFO preloaded with 15 entries, producer 3 sends 0xA0, 0xA1 -> 0xA0 written; fifo_full=1 so req_ready[3]=0 and no fifo_wr; consumer read clears full; 0xA1 written in that same cycle.
- fifo_rd_req=1 with FIFO non-empty during a 4-beat burst exit -> exactly one GAP cycle with fifo_wr=0, then IDLE.
- Producer 1 drops valid after 2 beats -> burst ends, last_grant=1; a pending producer 2 is granted next.
- rst asserted mid-burst after beat 2 -> next cycle grant_valid=0, fifo_wr=0; after release, producer 0 has first priority.
